gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, number of wait cycles between driving a vector and sampling the gate output; legal range 0..15.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request one full sweep; sampled only in IDLE.
REQ-005 Port: a_o  output  1  gate input a drive, registered.
REQ-006 Port: b_o  output  1  gate input b drive, registered.
REQ-007 Port: c_i  input  1  gate output c under test.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: done  output  1  one-cycle pulse on sweep completion.
REQ-010 Port: pass  output  1  sweep result, high when all four vectors matched.
REQ-011 Port: fail_count  output  3  number of mismatching vectors in last sweep, 0..4.
REQ-012 Port: result_vec  output  4  captured c_i per vector, bit index = {a,b}.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, DONE; a 2-bit vector index idx selects {a_o,b_o} = idx.
REQ-014 IDLE: a_o=b_o=0, busy=0; start=1 -> DRIVE with idx=0, fail_count cleared to 0, pass cleared to 0, result_vec cleared to 0.
REQ-015 DRIVE lasts exactly 1 cycle with {a_o,b_o}=idx; -> SETTLE if SETTLE_CYCLES>0, else -> SAMPLE.
REQ-016 SETTLE lasts exactly SETTLE_CYCLES cycles via down-counter; {a_o,b_o} held stable.
REQ-017 SAMPLE lasts 1 cycle; on the edge leaving SAMPLE, c_i is compared against expected a_o AND b_o; a mismatch increments fail_count.
REQ-018 After SAMPLE: idx<3 -> idx+1, DRIVE; idx==3 -> DONE; idx SHALL NOT wrap to 0 inside a sweep.
REQ-019 DONE lasts 1 cycle with done=1, pass=(fail_count==0) registered at the transition into DONE; -> IDLE.
REQ-020 Sweep latency: done SHALL be high in cycle 4*(SETTLE_CYCLES+2)+1 counting the start-accept edge as cycle 0 (17 for default).
REQ-021 pass, fail_count, result_vec SHALL hold their values after DONE until the next accepted start.
REQ-022 start high in any state other than IDLE (including DONE) SHALL be ignored and not queued.
REQ-023 start held high continuously SHALL launch back-to-back sweeps, one accepted per IDLE visit.
REQ-024 fail_count SHALL saturate at 4 and never wrap.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, idx=0, settle counter=0, a_o=0, b_o=0, busy=0, done=0, pass=0, fail_count=0, result_vec=0.
REQ-026 Reset asserted mid-sweep SHALL abort it with no done pulse; the first start after rst_n deasserts begins a fresh sweep at idx=0.

Configuration
REQ-027 Macro GATE_SWEEP_RESULT_LOG_EN defined: result_vec[idx] SHALL be loaded with c_i on the edge leaving SAMPLE.
REQ-028 Macro GATE_SWEEP_RESULT_LOG_EN undefined: result_vec SHALL be constant 4'b0000 with no capture registers; all other behaviour unchanged.

Verification
REQ-029 Correct AND gate on c_i, SETTLE_CYCLES=2, start pulse -> a_o/b_o sequence 00,01,10,11, done in cycle 17, pass=1, fail_count=0, result_vec=4'b1000 (log enabled).
REQ-030 c_i tied 1, SETTLE_CYCLES=2 -> pass=0, fail_count=3, result_vec=4'b1111 (log enabled) / 4'b0000 (log disabled).
REQ-031 SETTLE_CYCLES=0, correct gate -> done in cycle 9, pass=1, no cycle spent in SETTLE.
REQ-032 start re-pulsed in DRIVE of idx=2 and in the DONE cycle -> exactly one done pulse, next sweep only after a start seen in IDLE.
REQ-033 rst_n pulsed low in SETTLE of idx=1 -> all outputs 0 within the reset pulse, no done; subsequent start completes normally with pass=1.
REQ-034 c_i tied 0 (stuck-at-0) -> fail_count=1, pass=0, result values held until next start, then cleared on the start-accept edge.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive two-input AND-gate checker.
// Drives the four {a,b} vectors in order 00,01,10,11, waits SETTLE_CYCLES after
// each drive, samples the gate output c_i and compares it against a AND b.
// After the last vector it pulses done for one cycle and publishes pass,
// fail_count and (optionally) the captured c_i values.
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   start       request one sweep, only honoured in IDLE
//   a_o, b_o    registered gate input drives
//   c_i         gate output under test
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   pass        high when all four vectors matched
//   fail_count  number of mismatching vectors (0..4, saturating)
//   result_vec  captured c_i per vector, bit index = {a,b}
//
// Configuration macro:
//   GATE_SWEEP_RESULT_LOG_EN  defined: result_vec captures c_i per vector.
//                             undefined: result_vec is tied to 4'b0000.
module gate_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   input  logic       c_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] fail_count,
   output logic [3:0] result_vec
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned FC_W  = 3;
   localparam int unsigned VEC_N = 4;

   localparam logic [FC_W-1:0]  FC_MAX      = FC_W'(VEC_N);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(VEC_N - 1);
   localparam logic             HAS_SETTLE  = (SETTLE_CYCLES != 0);
   // Counter is loaded with SETTLE_CYCLES-1 so that SETTLE lasts SETTLE_CYCLES cycles
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES != 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FC_W-1:0]   fc_q, fc_d;
   logic              pass_q, pass_d;
   logic              a_q, a_d;
   logic              b_q, b_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              drive_c;
   logic              mismatch_c;
`ifdef GATE_SWEEP_RESULT_LOG_EN
   logic [VEC_N-1:0]  res_q, res_d;
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         fc_q    <= '0;
         pass_q  <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         fc_q    <= fc_d;
         pass_q  <= pass_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef GATE_SWEEP_RESULT_LOG_EN
   // Per-vector capture of the gate output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      fc_d       = fc_q;
      pass_d     = pass_q;
      mismatch_c = 1'b0;
`ifdef GATE_SWEEP_RESULT_LOG_EN
      res_d      = res_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = '0;
               fc_d    = '0;
               pass_d  = 1'b0;
`ifdef GATE_SWEEP_RESULT_LOG_EN
               res_d   = '0;
`endif
            end
         end
         S_DRIVE: begin
            if (HAS_SETTLE) begin
               state_d = S_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               state_d = S_SAMPLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            // Expected gate response is a AND b, i.e. the two index bits ANDed
            mismatch_c = (c_i != (idx_q[1] & idx_q[0]));
            if (mismatch_c && (fc_q != FC_MAX)) begin
               fc_d = fc_q + FC_W'(1);
            end
`ifdef GATE_SWEEP_RESULT_LOG_EN
            res_d[idx_q] = c_i;
`endif
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
               pass_d  = (fc_d == '0);
            end else begin
               state_d = S_DRIVE;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the state being entered so they are aligned with it
      drive_c = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      a_d     = drive_c & idx_d[1];
      b_d     = drive_c & idx_d[0];
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   assign a_o        = a_q;
   assign b_o        = b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_count = fc_q;
`ifdef GATE_SWEEP_RESULT_LOG_EN
   assign result_vec = res_q;
`else
   assign result_vec = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE_CYCLES 2 and 0), each
// checked every cycle against a sweep-schedule model, plus literal checks.
module tb_gate_sweep_ctrl;

`ifdef GATE_SWEEP_RESULT_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] start_r = 2'b00;
   logic [1:0] c_w;
   logic [1:0] a_w, b_w, busy_w, done_w, pass_w;
   logic [2:0] fc_w [2];
   logic [3:0] rv_w [2];
   int         md_r [2] = '{0, 0};

   int n_cmp = 0;
   int n_bad = 0;

   // Model state, per unit
   bit         m_act [2] = '{0, 0};
   int         m_k   [2] = '{0, 0};
   int         m_fail[2] = '{0, 0};
   bit         m_pass[2] = '{0, 0};
   logic [3:0] m_res [2] = '{4'b0, 4'b0};

   always #5 clk = ~clk;

   function automatic int s_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   // Gate under test: 0 = correct AND, 1 = stuck-at-1, 2 = stuck-at-0
   function automatic logic gate(input int md, input logic a, input logic b);
      if (md == 0) return a & b;
      if (md == 1) return 1'b1;
      return 1'b0;
   endfunction

   assign c_w[0] = gate(md_r[0], a_w[0], b_w[0]);
   assign c_w[1] = gate(md_r[1], a_w[1], b_w[1]);

   gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_r[0]), .a_o(a_w[0]), .b_o(b_w[0]),
      .c_i(c_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .fail_count(fc_w[0]), .result_vec(rv_w[0]));

   gate_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_r[1]), .a_o(a_w[1]), .b_o(b_w[1]),
      .c_i(c_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .fail_count(fc_w[1]), .result_vec(rv_w[1]));

   // Model: a sweep is a schedule of k = edges since the accept edge.
   // Vector v occupies k in [v*(S+2), v*(S+2)+S+1]; the gate is judged on the
   // edge that ends the last of those cycles; k == 4*(S+2) is the done cycle.
   always @(posedge clk or negedge rst_n) begin
      for (int u = 0; u < 2; u++) begin
         int s, l, v, o;
         s = s_of(u);
         l = 4 * (s + 2);
         if (!rst_n) begin
            m_act[u] = 0; m_k[u] = 0; m_fail[u] = 0; m_pass[u] = 0; m_res[u] = 4'b0;
         end else if (m_act[u]) begin
            if (m_k[u] == l) begin
               m_act[u] = 0;
            end else begin
               v = m_k[u] / (s + 2);
               o = m_k[u] % (s + 2);
               if (o == s + 1) begin
                  if (c_w[u] !== ((v == 3) ? 1'b1 : 1'b0) && m_fail[u] < 4) m_fail[u]++;
                  m_res[u][v] = c_w[u];
               end
               m_k[u]++;
               if (m_k[u] == l) m_pass[u] = (m_fail[u] == 0);
            end
         end else if (start_r[u]) begin
            m_act[u] = 1; m_k[u] = 0; m_fail[u] = 0; m_pass[u] = 0; m_res[u] = 4'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One sweep on unit u with gate mode md; optional re-pulses of start in
   // DRIVE of vector 2 and in the done cycle. Runs a fixed window of edges.
   task automatic run_sweep(input int u, input int md, input bit repulse,
                            output int lat, output int ndone, output int nbusy);
      int l;
      l = 4 * (s_of(u) + 2);
      lat = -1; ndone = 0; nbusy = 0;
      md_r[u] = md;
      start_r[u] = 1'b1;
      for (int n = 0; n < l + 6; n++) begin
         @(posedge clk); #1;
         start_r[u] = 1'b0;
         if (busy_w[u]) nbusy++;
         if (done_w[u]) begin
            ndone++;
            if (lat < 0) lat = n;
         end
         if (repulse && (n == 2 * (s_of(u) + 2) || (done_w[u] && n == lat))) start_r[u] = 1'b1;
      end
   endtask

   initial begin
      int lat, nd, nb;

      // Per-cycle comparison against the model, away from the rising edge
      fork
         forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
               int s, l, v;
               logic [11:0] exp_v, act_v;
               logic ea, eb, ebusy, edone;
               s = s_of(u);
               l = 4 * (s + 2);
               v = m_k[u] / (s + 2);
               ebusy = m_act[u];
               edone = m_act[u] && (m_k[u] == l);
               ea = m_act[u] && (m_k[u] < l) && v[1];
               eb = m_act[u] && (m_k[u] < l) && v[0];
               exp_v = {ea, eb, ebusy, edone, m_pass[u], 3'(m_fail[u]), LOG ? m_res[u] : 4'b0};
               act_v = {a_w[u], b_w[u], busy_w[u], done_w[u], pass_w[u], fc_w[u], rv_w[u]};
               n_cmp++;
               if (act_v !== exp_v) begin
                  n_bad++;
                  $display("FAIL cycle_u%0d {a,b,busy,done,pass,fc,res}: got %b expected %b at %0t",
                           u, act_v, exp_v, $time);
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", int'(busy_w), 0);
      check("reset_fc_u0", int'(fc_w[0]), 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Correct gate, SETTLE_CYCLES=2: done 16 edges after accept (cycle 17)
      run_sweep(0, 0, 1'b0, lat, nd, nb);
      check("s2_ok_latency", lat, 16);
      check("s2_ok_ndone", nd, 1);
      check("s2_ok_pass", int'(pass_w[0]), 1);
      check("s2_ok_fc", int'(fc_w[0]), 0);
      check("s2_ok_res", int'(rv_w[0]), LOG ? 8 : 0);

      // Stuck-at-1
      run_sweep(0, 1, 1'b0, lat, nd, nb);
      check("s2_st1_pass", int'(pass_w[0]), 0);
      check("s2_st1_fc", int'(fc_w[0]), 3);
      check("s2_st1_res", int'(rv_w[0]), LOG ? 15 : 0);

      // SETTLE_CYCLES=0: done 8 edges after accept (cycle 9), busy 9 cycles
      run_sweep(1, 0, 1'b0, lat, nd, nb);
      check("s0_ok_latency", lat, 8);
      check("s0_ok_pass", int'(pass_w[1]), 1);
      check("s0_ok_busy_cycles", nb, 9);

      // Stuck-at-0: results held, then cleared on the next accept edge
      run_sweep(0, 2, 1'b0, lat, nd, nb);
      check("s2_st0_fc", int'(fc_w[0]), 1);
      check("s2_st0_pass", int'(pass_w[0]), 0);
      check("s2_st0_res", int'(rv_w[0]), 0);
      repeat (5) @(posedge clk);
      #1;
      check("s2_st0_hold_fc", int'(fc_w[0]), 1);
      md_r[0] = 0;
      start_r[0] = 1'b1;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      check("s2_accept_clr_fc", int'(fc_w[0]), 0);
      check("s2_accept_busy", int'(busy_w[0]), 1);
      repeat (20) @(posedge clk);
      #1;
      check("s2_drained", int'(busy_w[0]), 0);

      // Start re-pulsed in DRIVE of vector 2 and in DONE: only one sweep
      run_sweep(0, 0, 1'b1, lat, nd, nb);
      check("repulse_ndone", nd, 1);
      check("repulse_idle_after", int'(busy_w[0]), 0);

      // Reset in SETTLE of vector 1: abort, no done
      md_r[0] = 0;
      start_r[0] = 1'b1;
      nd = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         start_r[0] = 1'b0;
         if (done_w[0]) nd++;
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", int'(busy_w[0]), 0);
      check("rst_mid_ab", int'({a_w[0], b_w[0]}), 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (done_w[0]) nd++;
      end
      check("rst_mid_no_done", nd, 0);
      run_sweep(0, 0, 1'b0, lat, nd, nb);
      check("rst_after_latency", lat, 16);
      check("rst_after_pass", int'(pass_w[0]), 1);

      // Start held high: back-to-back sweeps, accepts 18 edges apart
      start_r[0] = 1'b1;
      nd = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done_w[0]) nd++;
      end
      start_r[0] = 1'b0;
      check("b2b_ndone", nd, 2);
      repeat (20) @(posedge clk);
      #1;
      check("b2b_drained", int'(busy_w[0]), 0);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
